// File: rtl/rgmii_rx_speed_adapter.sv
// RGMII receive adapter: turns DDR-captured RXD/RX_CTL samples into a GMII byte stream for
// 10/100/1000 operation, and decodes the in-band link status and false-carrier indications.
module rgmii_rx_speed_adapter #(
    parameter int PIPE_STAGES   = 1,
    parameter bit AUTO_SPEED    = 1'b1,
    parameter bit ALIGN_SFD     = 1'b1,
    parameter int STATUS_FILTER = 4
) (
    input  logic       rgmii_rxc,
    input  logic       rst_n,
    input  logic [3:0] rx_d_h,
    input  logic [3:0] rx_d_l,
    input  logic       rx_ctl_h,
    input  logic       rx_ctl_l,
    input  logic [1:0] speed_sel,
    output logic [7:0] gmii_rx_d,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_ce,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex,
    output logic       false_carrier
);
    localparam logic [3:0] FILTER_MAX = 4'(STATUS_FILTER);
    localparam int         OUT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] mode_reg, mode_next;
    logic       phase_reg, phase_next;
    logic [3:0] nib_reg, nib_next;
    logic       nib_er_reg, nib_er_next;
    logic       dv_prev_reg;

    logic [3:0] status_prev_reg;
    logic [3:0] status_cnt_reg, status_cnt_next;
    logic       status_link_reg, status_link_next;
    logic [1:0] status_speed_reg, status_speed_next;
    logic       status_duplex_reg, status_duplex_next;
    logic       fc_cond_reg;

    logic       dv, er, dv_rise, frame_start, gig, sfd_early;
    logic       status_sample, fc_cond, fc_pulse;
    logic [1:0] eff_speed, cur_mode;
    logic [7:0] byte_d;
    logic       byte_dv, byte_er, byte_ce;

    assign dv          = rx_ctl_h;
    assign er          = rx_ctl_h ^ rx_ctl_l;
    assign dv_rise     = dv & ~dv_prev_reg;
    assign frame_start = (state_reg == ST_IDLE) && dv_rise;
    assign eff_speed   = AUTO_SPEED ? status_speed_reg : speed_sel;
    // The frame's own mode must already apply on the cycle that starts it.
    assign cur_mode    = frame_start ? eff_speed : mode_reg;
    assign gig         = cur_mode[1];
    assign sfd_early   = ALIGN_SFD && (state_reg == ST_PREAMBLE) && !phase_reg && (rx_d_h == 4'hD);

    // dv_prev resets high so a frame already in flight at reset release is not taken as a start.
    always_ff @(posedge rgmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            mode_reg    <= 2'b00;
            phase_reg   <= 1'b0;
            nib_reg     <= 4'h0;
            nib_er_reg  <= 1'b0;
            dv_prev_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            phase_reg   <= phase_next;
            nib_reg     <= nib_next;
            nib_er_reg  <= nib_er_next;
            dv_prev_reg <= dv;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        phase_next  = phase_reg;
        nib_next    = nib_reg;
        nib_er_next = nib_er_reg;
        case (state_reg)
            ST_IDLE: begin
                phase_next = 1'b0;
                if (frame_start) begin
                    mode_next = eff_speed;
                    if (eff_speed[1]) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next  = ST_PREAMBLE;
                        phase_next  = 1'b1;
                        nib_next    = rx_d_h;
                        nib_er_next = er;
                    end
                end
            end
            ST_PREAMBLE, ST_DATA: begin
                if (!dv) begin
                    state_next = ST_IDLE;
                    phase_next = 1'b0;
                end else if (!gig) begin
                    if (sfd_early) begin
                        state_next = ST_DATA;
                    end else if (!phase_reg) begin
                        phase_next  = 1'b1;
                        nib_next    = rx_d_h;
                        nib_er_next = er;
                    end else begin
                        phase_next = 1'b0;
                        if (state_reg == ST_PREAMBLE && (!ALIGN_SFD || {rx_d_h, nib_reg} == 8'hD5))
                            state_next = ST_DATA;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_d  = 8'h00;
        byte_dv = 1'b0;
        byte_er = 1'b0;
        byte_ce = 1'b0;
        if (gig) begin
            byte_ce = 1'b1;
            byte_d  = {rx_d_l, rx_d_h};
            byte_dv = dv;
            byte_er = er;
        end else if (state_reg != ST_IDLE) begin
            if (!dv) begin
                // Frame ended on a half byte: flush it flagged as errored.
                if (phase_reg) begin
                    byte_ce = 1'b1;
                    byte_d  = {4'h0, nib_reg};
                    byte_dv = 1'b1;
                    byte_er = 1'b1;
                end
            end else if (sfd_early) begin
                byte_ce = 1'b1;
                byte_d  = 8'hD5;
                byte_dv = 1'b1;
                byte_er = er;
            end else if (phase_reg) begin
                byte_ce = 1'b1;
                byte_d  = {rx_d_h, nib_reg};
                byte_dv = 1'b1;
                byte_er = er | nib_er_reg;
            end
        end
    end

    assign status_sample = !rx_ctl_h && !rx_ctl_l;

    always_ff @(posedge rgmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            status_prev_reg   <= 4'h0;
            status_cnt_reg    <= 4'h0;
            status_link_reg   <= 1'b0;
            status_speed_reg  <= 2'b00;
            status_duplex_reg <= 1'b0;
            fc_cond_reg       <= 1'b0;
        end else begin
            if (status_sample)
                status_prev_reg <= rx_d_h;
            status_cnt_reg    <= status_cnt_next;
            status_link_reg   <= status_link_next;
            status_speed_reg  <= status_speed_next;
            status_duplex_reg <= status_duplex_next;
            fc_cond_reg       <= fc_cond;
        end
    end

    always_comb begin
        status_cnt_next    = status_cnt_reg;
        status_link_next   = status_link_reg;
        status_speed_next  = status_speed_reg;
        status_duplex_next = status_duplex_reg;
        if (status_sample) begin
            if (rx_d_h != status_prev_reg)
                status_cnt_next = 4'd1;
            else if (status_cnt_reg != FILTER_MAX)
                status_cnt_next = status_cnt_reg + 4'd1;
            if (status_cnt_next == FILTER_MAX) begin
                status_link_next   = rx_d_h[0];
                status_speed_next  = rx_d_h[2:1];
                status_duplex_next = rx_d_h[3];
            end
        end
    end

    assign fc_cond  = !rx_ctl_h && rx_ctl_l && (rx_d_h == 4'hE);
    assign fc_pulse = fc_cond && !fc_cond_reg && !dv_rise;

    // Every output travels the same register chain so all ports share one latency.
    logic [PIPE_STAGES:0][OUT_W-1:0] pipe_chain;

    assign pipe_chain[0] = {byte_d, byte_dv, byte_er, byte_ce, status_link_next,
                            status_speed_next, status_duplex_next, fc_pulse};

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_pipe
            logic [OUT_W-1:0] stage_reg;
            always_ff @(posedge rgmii_rxc or negedge rst_n) begin
                if (!rst_n)
                    stage_reg <= '0;
                else
                    stage_reg <= pipe_chain[gi];
            end
            assign pipe_chain[gi+1] = stage_reg;
        end
    endgenerate

    assign {gmii_rx_d, gmii_rx_dv, gmii_rx_er, gmii_rx_ce, link_up,
            link_speed, link_duplex, false_carrier} = pipe_chain[PIPE_STAGES];

endmodule

// File: tb/tb_rgmii_rx_speed_adapter.sv
// Randomized and directed bench for rgmii_rx_speed_adapter; expected byte streams come from a
// nibble-pairing reference model, one line per checked transaction.
module tb_rgmii_rx_speed_adapter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx_d_h, rx_d_l;
    logic       rx_ctl_h, rx_ctl_l;
    logic [1:0] speed_sel;
    logic [7:0] gmii_rx_d;
    logic       gmii_rx_dv, gmii_rx_er, gmii_rx_ce;
    logic       link_up, link_duplex, false_carrier;
    logic [1:0] link_speed;

    int vectors = 0;
    int miscompares = 0;
    int fc_cnt = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    rgmii_rx_speed_adapter #(
        .PIPE_STAGES  (1),
        .AUTO_SPEED   (1'b0),
        .ALIGN_SFD    (1'b1),
        .STATUS_FILTER(4)
    ) dut (
        .rgmii_rxc    (clk),
        .rst_n        (rst_n),
        .rx_d_h       (rx_d_h),
        .rx_d_l       (rx_d_l),
        .rx_ctl_h     (rx_ctl_h),
        .rx_ctl_l     (rx_ctl_l),
        .speed_sel    (speed_sel),
        .gmii_rx_d    (gmii_rx_d),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .gmii_rx_ce   (gmii_rx_ce),
        .link_up      (link_up),
        .link_speed   (link_speed),
        .link_duplex  (link_duplex),
        .false_carrier(false_carrier)
    );

    always #5 clk = ~clk;

    // Collect every frame byte ({er, d}) and count false-carrier pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gmii_rx_ce && gmii_rx_dv)
                got_q.push_back({gmii_rx_er, gmii_rx_d});
            if (false_carrier)
                fc_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] h, input logic [3:0] l, input logic ch, input logic cl);
        rx_d_h = h; rx_d_l = l; rx_ctl_h = ch; rx_ctl_l = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] st);
        repeat (n) drive(st, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic e);
        drive(b[3:0], b[7:4], 1'b1, ~e);
    endtask

    task automatic drive_nib(input logic [3:0] n, input logic e);
        drive(n, 4'($urandom), 1'b1, ~e);
    endtask

    // 10/100 reference: bytes are low-nibble-first pairs; a lone SFD nibble on an even index
    // stands for a whole D5 byte, and a trailing unpaired nibble becomes {0,n} with error.
    function automatic void model_mii(input logic [3:0] nibs[$], input logic ers[$]);
        int n = nibs.size();
        int sfd = -1;
        int start;
        for (int i = 0; i < n; i++)
            if (nibs[i] == 4'hD) begin sfd = i; break; end
        for (int i = 0; i + 1 <= sfd; i += 2)
            exp_q.push_back({ers[i] | ers[i+1], nibs[i+1], nibs[i]});
        if (sfd >= 0 && sfd % 2 == 0)
            exp_q.push_back({ers[sfd], 8'hD5});
        start = sfd + 1;
        for (int i = start; i + 1 < n; i += 2)
            exp_q.push_back({ers[i] | ers[i+1], nibs[i+1], nibs[i]});
        if ((n - start) % 2 == 1)
            exp_q.push_back({1'b1, 4'h0, nibs[n-1]});
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; speed_sel = 2'b10;
        rx_d_h = 4'h0; rx_d_l = 4'h0; rx_ctl_h = 1'b0; rx_ctl_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_data got=%h exp=000", {gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d});
        end
        vectors++;
        if ({link_up, link_speed, link_duplex, false_carrier} !== 5'h0) begin
            miscompares++;
            $display("FAIL reset_status got=%b exp=00000", {link_up, link_speed, link_duplex, false_carrier});
        end
        rst_n = 1'b1;
        idle(6, 4'h0);
        vectors++;
        if (gmii_rx_ce !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_ce got=%b exp=0", gmii_rx_ce);
        end
        $display("test_reset done: vectors=%0d miscompares=%0d", vectors, miscompares);
    endtask

    task automatic test_gig_frame();
        logic [7:0] b;
        speed_sel = 2'b10;
        idle(2, 4'h0);
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 72; i++) begin
            b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(i - 7);
            drive_byte(b, 1'b0);
            exp_q.push_back({1'b0, b});
            if (i == 0) begin
                vectors++;
                if ({gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d} !== {3'b110, 8'h55}) begin
                    miscompares++;
                    $display("FAIL gig_latency got=%h exp=655", {gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d});
                end
            end
        end
        drive(4'h0, 4'h9, 1'b0, 1'b0);
        vectors++;
        if ({gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d} !== {3'b100, 8'h90}) begin
            miscompares++;
            $display("FAIL gig_idle_pass got=%h exp=490", {gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d});
        end
        drive(4'hF, 4'h3, 1'b0, 1'b1);
        vectors++;
        if ({gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d} !== {3'b101, 8'h3F}) begin
            miscompares++;
            $display("FAIL gig_idle_er got=%h exp=53f", {gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d});
        end
        idle(2, 4'h0);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL gig_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL gig_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_gig_frame done: %0d bytes", exp_q.size());
    endtask

    task automatic test_mii_aligned();
        logic [3:0] nibs[$];
        speed_sel = 2'b01;
        for (int v = 0; v < 2; v++) begin
            idle(3, 4'h0);
            got_q.delete(); exp_q.delete(); nibs.delete();
            repeat (14) nibs.push_back(4'h5);
            nibs.push_back(4'hD); nibs.push_back(4'h1); nibs.push_back(4'h0);
            nibs.push_back(4'h2); nibs.push_back(4'h0);
            if (v == 1) nibs.push_back(4'h7);
            repeat (7) exp_q.push_back(9'h055);
            exp_q.push_back(9'h0D5); exp_q.push_back(9'h001); exp_q.push_back(9'h002);
            if (v == 1) exp_q.push_back(9'h107);
            for (int i = 0; i < nibs.size(); i++) begin
                drive_nib(nibs[i], 1'b0);
                if (i == 14) begin
                    vectors++;
                    if ({gmii_rx_ce, gmii_rx_d} !== 9'h1D5) begin
                        miscompares++;
                        $display("FAIL mii_aligned_sfd got=%h exp=1d5", {gmii_rx_ce, gmii_rx_d});
                    end
                end
            end
            idle(3, 4'h0);
            vectors++;
            if (got_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL mii_aligned_len v%0d got=%0d exp=%0d", v, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL mii_aligned_byte v%0d/%0d got=%h exp=%h", v, i, got_q[i], exp_q[i]);
                end
            end
            $display("test_mii_aligned variant %0d done: %0d bytes", v, exp_q.size());
        end
    endtask

    task automatic test_mii_misaligned();
        speed_sel = 2'b00;
        idle(3, 4'h0);
        got_q.delete(); exp_q.delete();
        repeat (7) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5); exp_q.push_back(9'h043);
        for (int i = 0; i < 15; i++) drive_nib(4'h5, 1'b0);
        vectors++;
        if (gmii_rx_ce !== 1'b0) begin
            miscompares++;
            $display("FAIL mii_mis_half got_ce=%b exp=0", gmii_rx_ce);
        end
        drive_nib(4'hD, 1'b0);
        vectors++;
        if ({gmii_rx_ce, gmii_rx_d} !== 9'h1D5) begin
            miscompares++;
            $display("FAIL mii_mis_sfd got=%h exp=1d5", {gmii_rx_ce, gmii_rx_d});
        end
        drive_nib(4'h3, 1'b0);
        drive_nib(4'h4, 1'b0);
        idle(3, 4'h0);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL mii_mis_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL mii_mis_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_mii_misaligned done: %0d bytes", exp_q.size());
    endtask

    task automatic test_speed_sel_midframe();
        logic [3:0] nibs[$];
        logic       ers[$];
        speed_sel = 2'b01;
        idle(2, 4'h0);
        got_q.delete(); exp_q.delete();
        repeat (4) begin nibs.push_back(4'h5); ers.push_back(1'b0); end
        nibs.push_back(4'hD); ers.push_back(1'b0);
        repeat (8) begin nibs.push_back(4'($urandom)); ers.push_back(1'b0); end
        model_mii(nibs, ers);
        for (int i = 0; i < nibs.size(); i++) begin
            drive_nib(nibs[i], ers[i]);
            if (i == 6) speed_sel = 2'b10;
        end
        idle(3, 4'h0);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL speed_sel_mid_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL speed_sel_mid_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_speed_sel_midframe done: %0d bytes", exp_q.size());
    endtask

    task automatic test_random_frames();
        logic [3:0] nibs[$];
        logic       ers[$];
        logic [7:0] b;
        logic       e;
        for (int f = 0; f < 12; f++) begin
            speed_sel = 2'($urandom_range(0, 3));
            idle(2, 4'h0);
            got_q.delete(); exp_q.delete(); nibs.delete(); ers.delete();
            if (speed_sel[1]) begin
                for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
                    b = 8'($urandom);
                    e = ($urandom_range(0, 7) == 0);
                    drive_byte(b, e);
                    exp_q.push_back({e, b});
                end
            end else begin
                repeat ($urandom_range(1, 16)) nibs.push_back(4'h5);
                nibs.push_back(4'hD);
                repeat ($urandom_range(0, 15)) nibs.push_back(4'($urandom));
                for (int i = 0; i < nibs.size(); i++) ers.push_back($urandom_range(0, 7) == 0);
                model_mii(nibs, ers);
                for (int i = 0; i < nibs.size(); i++) drive_nib(nibs[i], ers[i]);
            end
            idle(3, 4'h0);
            vectors++;
            if (got_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL rand_len frame%0d got=%0d exp=%0d", f, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rand_byte frame%0d/%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]);
                end
            end
            $display("random frame %0d speed=%b bytes=%0d", f, speed_sel, exp_q.size());
        end
    endtask

    task automatic test_status();
        logic [3:0] exp_st;
        idle(5, 4'h0);
        for (int k = 0; k < 4; k++) begin
            drive(4'hD, 4'h0, 1'b0, 1'b0);
            exp_st = (k == 3) ? 4'b1101 : 4'b0000;
            vectors++;
            if ({link_up, link_speed, link_duplex} !== exp_st) begin
                miscompares++;
                $display("FAIL status_d%0d got=%b exp=%b", k, {link_up, link_speed, link_duplex}, exp_st);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) drive(4'h3, 4'h0, 1'b0, 1'b1);
            drive(4'h5, 4'h0, 1'b0, 1'b0);
            exp_st = (k == 3) ? 4'b1100 : 4'b1101;
            vectors++;
            if ({link_up, link_speed, link_duplex} !== exp_st) begin
                miscompares++;
                $display("FAIL status_hold%0d got=%b exp=%b", k, {link_up, link_speed, link_duplex}, exp_st);
            end
        end
        idle(5, 4'h0);
        vectors++;
        if ({link_up, link_speed, link_duplex} !== 4'b0000) begin
            miscompares++;
            $display("FAIL status_clear got=%b exp=0000", {link_up, link_speed, link_duplex});
        end
        $display("test_status done");
    endtask

    task automatic test_false_carrier();
        int   base;
        logic exp_fc;
        idle(2, 4'h0);
        base = fc_cnt;
        for (int k = 0; k < 5; k++) begin
            drive(4'hE, 4'h0, 1'b0, 1'b1);
            exp_fc = (k == 0);
            vectors++;
            if (false_carrier !== exp_fc) begin
                miscompares++;
                $display("FAIL fc_cycle%0d got=%b exp=%b", k, false_carrier, exp_fc);
            end
        end
        idle(2, 4'h0);
        vectors++;
        if (fc_cnt - base != 1) begin
            miscompares++;
            $display("FAIL fc_count got=%0d exp=1", fc_cnt - base);
        end
        drive(4'hF, 4'h0, 1'b0, 1'b1);
        vectors++;
        if (false_carrier !== 1'b0) begin
            miscompares++;
            $display("FAIL fc_not_e got=%b exp=0", false_carrier);
        end
        drive(4'hE, 4'h0, 1'b0, 1'b1);
        vectors++;
        if (false_carrier !== 1'b1) begin
            miscompares++;
            $display("FAIL fc_rearm got=%b exp=1", false_carrier);
        end
        idle(2, 4'h0);
        $display("test_false_carrier done: pulses=%0d", fc_cnt - base);
    endtask

    task automatic test_reset_midframe();
        speed_sel = 2'b10;
        idle(2, 4'h0);
        for (int i = 0; i < 3; i++) drive_byte(8'h55, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d, link_up, link_speed, link_duplex, false_carrier} !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_mid_async got=%h exp=0000",
                     {gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d, link_up, link_speed, link_duplex, false_carrier});
        end
        drive_byte(8'h55, 1'b0);
        vectors++;
        if ({gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d} !== 11'h0) begin
            miscompares++;
            $display("FAIL rst_mid_next got=%h exp=000", {gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rx_d});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_byte(8'h5A, 1'b0);
            vectors++;
            if (gmii_rx_ce !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_dv_held%0d got_ce=%b exp=0", i, gmii_rx_ce);
            end
        end
        idle(2, 4'h0);
        drive_byte(8'hA5, 1'b0);
        vectors++;
        if ({gmii_rx_ce, gmii_rx_dv, gmii_rx_d} !== {2'b11, 8'hA5}) begin
            miscompares++;
            $display("FAIL rst_restart got=%h exp=3a5", {gmii_rx_ce, gmii_rx_dv, gmii_rx_d});
        end
        idle(2, 4'h0);
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_gig_frame();
        test_mii_aligned();
        test_mii_misaligned();
        test_speed_sel_midframe();
        test_random_frames();
        test_status();
        test_false_carrier();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
